// File: rtl/regfile_pkg.sv
// Shared constants for the CPU register file and its users.
package regfile_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
  // MIPS ABI names for the stack pointer and return address registers.
  localparam logic [REG_ADDR_WIDTH-1:0] SP = 5'd29;
  localparam logic [REG_ADDR_WIDTH-1:0] RA = 5'd31;

endpackage

// File: rtl/register32.sv
// WIDTH-bit storage register: synchronous load enable, asynchronous active-high clear.
module register32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// entry 0 hardwired to zero, optional same-cycle write-to-read forwarding.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH      = WORD_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [WIDTH-1:0]      read_data1,
  output logic [WIDTH-1:0]      read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:1]            wr_en;
  logic [DEPTH-1:0][WIDTH-1:0] entry_q;

  // One-hot write decode; index 0 has no storage so it never gets an enable.
  always_comb begin
    wr_en = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wr_en[i] = write_enable && (write_addr == ADDR_WIDTH'(i));
    end
  end

  assign entry_q[0] = '0;

  for (genvar g = 1; g < DEPTH; g++) begin : g_entry
    register32 #(.WIDTH(WIDTH)) u_reg (
      .clk_i (clk),
      .rst_i (reset),
      .en_i  (wr_en[g]),
      .d_i   (write_data),
      .q_o   (entry_q[g])
    );
  end

  // Forwarding is suppressed during reset so reads stay 0 while reset is held.
  always_comb begin
    read_data1 = entry_q[read_addr1];
    read_data2 = entry_q[read_addr2];
    if (BYPASS && !reset && write_enable && write_addr != '0) begin
      if (write_addr == read_addr1) read_data1 = write_data;
      if (write_addr == read_addr2) read_data2 = write_data;
    end
  end

endmodule
